// File: rtl/hamming_minmax_engine.sv
// Reads N_WORDS 16-bit operands from byte memory, finds the min and max pairwise
// Hamming distance over all pairs j<k, and writes both results back to memory.
module hamming_minmax_engine #(
  parameter int unsigned N_WORDS   = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned RES_ADDR  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       mem_wen,
  output logic [7:0] mem_wdata,
  output logic [4:0] min_j,
  output logic [4:0] min_k,
  output logic [4:0] max_j,
  output logic [4:0] max_k
);

  localparam int unsigned NB = 2 * N_WORDS;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned DW = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PAIR, S_WR_MIN, S_WR_MAX, S_DONE
  } state_t;

  state_t          state;
  logic            armed;
  logic            skip_done;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   pj;
  logic [IW-1:0]   pk;
  logic [DW-1:0]   min_d;
  logic [DW-1:0]   max_d;
  logic [15:0]     cache [N_WORDS];
  logic [IW-1:0]   widx_c;
  logic [DW-1:0]   dist_c;

  function automatic logic [DW-1:0] popcount16(input logic [15:0] v);
    logic [DW-1:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + DW'(v[i]);
    return n;
  endfunction

  always_comb begin
    widx_c = IW'(cnt >> 1);
    dist_c = popcount16(cache[pj] ^ cache[pk]);
  end

  // Operand cache: even byte fills the high half, odd byte the low half.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      if (cnt[0]) cache[widx_c][7:0]  <= mem_rdata;
      else        cache[widx_c][15:8] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      skip_done <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      cnt       <= '0;
      pj        <= '0;
      pk        <= '0;
      min_d     <= DW'(16);
      max_d     <= '0;
      min_j     <= '0;
      min_k     <= '0;
      max_j     <= '0;
      max_k     <= '0;
    end else begin
      mem_wen <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed     <= 1'b0;
            skip_done <= 1'b0;
            state     <= S_LOAD;
            cnt       <= '0;
            mem_addr  <= 8'(BASE_ADDR);
            pj        <= '0;
            pk        <= IW'(1);
            min_d     <= DW'(16);
            max_d     <= '0;
            min_j     <= '0;
            min_k     <= '0;
            max_j     <= '0;
            max_k     <= '0;
          end
        end
        S_LOAD: begin
          if (start) begin
            state <= S_IDLE;
            armed <= 1'b1;
          end else if (cnt == CW'(NB - 1)) begin
            state <= (N_WORDS > 1) ? S_PAIR : S_WR_MIN;
          end else begin
            cnt      <= cnt + CW'(1);
            mem_addr <= 8'(BASE_ADDR + 32'(cnt) + 1);
          end
        end
        S_PAIR: begin
          if (start) begin
            state <= S_IDLE;
            armed <= 1'b1;
          end else begin
            // Strict compares: the earliest pair in scan order keeps ties.
            if (dist_c < min_d) begin
              min_d <= dist_c;
              min_j <= 5'(pj);
              min_k <= 5'(pk);
            end
            if (dist_c > max_d) begin
              max_d <= dist_c;
              max_j <= 5'(pj);
              max_k <= 5'(pk);
            end
            if (pk == IW'(N_WORDS - 1)) begin
              if (pj == IW'(N_WORDS - 2)) begin
                state <= S_WR_MIN;
              end else begin
                pj <= pj + IW'(1);
                pk <= pj + IW'(2);
              end
            end else begin
              pk <= pk + IW'(1);
            end
          end
        end
        S_WR_MIN: begin
          mem_addr  <= 8'(RES_ADDR);
          mem_wdata <= {3'b000, min_d};
          mem_wen   <= 1'b1;
          skip_done <= start;
          state     <= S_WR_MAX;
        end
        S_WR_MAX: begin
          mem_addr  <= 8'(RES_ADDR + 1);
          mem_wdata <= {3'b000, max_d};
          mem_wen   <= 1'b1;
          if (skip_done) begin
            state <= S_IDLE;
            armed <= 1'b1;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_IDLE;
            armed <= 1'b1;
            done  <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_minmax_engine.sv
// Directed bench for hamming_minmax_engine with a behavioural byte memory.
module tb_hamming_minmax_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_wen;
  logic [7:0] mem_wdata;
  logic [4:0] min_j, min_k, max_j, max_k;

  logic [7:0]  mem [256];
  logic [15:0] w [32];
  int          wen_cnt;
  int          n_cmp;
  int          n_err;
  int          lat;

  hamming_minmax_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .min_j(min_j), .min_k(min_k),
    .max_j(max_j), .max_k(max_k)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr] = mem_wdata;
      wen_cnt = wen_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 32; i++) begin
      mem[2*i]   = w[i][15:8];
      mem[2*i+1] = w[i][7:0];
    end
  endtask

  // Arm, launch, then count cycles from the launch edge until done is seen.
  task automatic launch_wait(output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    cycles = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic launch_only();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
  endtask

  task automatic model(output int mn, output int mx, output int mnj, output int mnk,
                       output int mxj, output int mxk);
    int d;
    logic [15:0] x;
    mn = 16; mx = 0; mnj = 0; mnk = 0; mxj = 0; mxk = 0;
    for (int j = 0; j < 31; j++) begin
      for (int k = j + 1; k < 32; k++) begin
        x = w[j] ^ w[k];
        d = $countones(x);
        if (d < mn) begin mn = d; mnj = j; mnk = k; end
        if (d > mx) begin mx = d; mxj = j; mxk = k; end
      end
    end
  endtask

  initial begin
    int e_mn, e_mx, e_mnj, e_mnk, e_mxj, e_mxk;
    n_cmp = 0; n_err = 0; wen_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done", 32'(done), 0);
    chk("reset_wen", 32'(mem_wen), 0);
    chk("reset_addr", 32'(mem_addr), 0);
    chk("reset_wdata", 32'(mem_wdata), 0);
    chk("reset_idx", 32'({min_j, min_k, max_j, max_k}), 0);
    rst_n = 1'b1;

    // 1: single all-ones word among zeros
    for (int i = 0; i < 32; i++) w[i] = 16'h0000;
    w[5] = 16'hFFFF;
    load_mem();
    wen_cnt = 0;
    launch_wait(lat);
    chk("t1_latency", 32'(lat), 563);
    chk("t1_min", 32'(mem[64]), 0);
    chk("t1_max", 32'(mem[65]), 16);
    chk("t1_min_pair", 32'({min_j, min_k}), 32'({5'd0, 5'd1}));
    chk("t1_max_pair", 32'({max_j, max_k}), 32'({5'd0, 5'd5}));
    repeat (5) @(posedge clk);
    #1;
    chk("t1_done_held", 32'(done), 1);
    chk("t1_wen_idle", 32'(mem_wen), 0);

    // 2: alternating patterns, ties resolve to first pair
    for (int i = 0; i < 32; i++) w[i] = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
    load_mem();
    launch_wait(lat);
    chk("t2_latency", 32'(lat), 563);
    chk("t2_min", 32'(mem[64]), 0);
    chk("t2_max", 32'(mem[65]), 16);
    chk("t2_min_pair", 32'({min_j, min_k}), 32'({5'd0, 5'd2}));
    chk("t2_max_pair", 32'({max_j, max_k}), 32'({5'd0, 5'd1}));

    // 3: word i = i
    for (int i = 0; i < 32; i++) w[i] = 16'(i);
    load_mem();
    wen_cnt = 0;
    launch_wait(lat);
    chk("t3_min", 32'(mem[64]), 1);
    chk("t3_max", 32'(mem[65]), 5);
    chk("t3_min_pair", 32'({min_j, min_k}), 32'({5'd0, 5'd1}));
    chk("t3_max_pair", 32'({max_j, max_k}), 32'({5'd0, 5'd31}));
    chk("t3_wen_pulses", 32'(wen_cnt), 2);

    // 4: abort at PAIR cycle 100, then relaunch
    mem[64] = 8'hEE;
    mem[65] = 8'hDD;
    wen_cnt = 0;
    launch_only();
    repeat (164) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    chk("t4_done_low", 32'(done), 0);
    chk("t4_no_writes", 32'(wen_cnt), 0);
    chk("t4_mem64", 32'(mem[64]), 32'h0EE);
    chk("t4_mem65", 32'(mem[65]), 32'h0DD);
    launch_wait(lat);
    chk("t4_relaunch_lat", 32'(lat), 563);
    chk("t4_relaunch_min", 32'(mem[64]), 1);
    chk("t4_relaunch_max", 32'(mem[65]), 5);

    // 5: asynchronous reset mid-PAIR; start=0 alone must not launch afterwards
    launch_only();
    repeat (164) @(posedge clk);
    @(negedge clk);
    chk("t5_pre_reset_mink", 32'(min_k), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_addr", 32'(mem_addr), 0);
    chk("t5_rst_wen", 32'(mem_wen), 0);
    chk("t5_rst_idx", 32'({min_j, min_k, max_j, max_k}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wen_cnt = 0;
    repeat (600) @(posedge clk);
    #1;
    chk("t5_no_launch_done", 32'(done), 0);
    chk("t5_no_launch_addr", 32'(mem_addr), 0);
    chk("t5_no_launch_wen", 32'(wen_cnt), 0);

    // 6: back-to-back launches on random data
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 32; i++) w[i] = 16'($urandom);
      load_mem();
      model(e_mn, e_mx, e_mnj, e_mnk, e_mxj, e_mxk);
      launch_wait(lat);
      chk("t6_latency", 32'(lat), 563);
      chk("t6_min", 32'(mem[64]), 32'(e_mn));
      chk("t6_max", 32'(mem[65]), 32'(e_mx));
      chk("t6_min_j", 32'(min_j), 32'(e_mnj));
      chk("t6_min_k", 32'(min_k), 32'(e_mnk));
      chk("t6_max_j", 32'(max_j), 32'(e_mxj));
      chk("t6_max_k", 32'(max_k), 32'(e_mxk));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
